// File: rtl/core_ex_wbck.sv
// Write-back arbitration ahead of the integer regfile write port: LSU has priority,
// and the ALU is granted once after STARVE_MAX consecutive blocked cycles.
module core_ex_wbck #(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alu_wbck_valid,
    output logic               alu_wbck_ready,
    input  logic               alu_wbck_wen,
    input  logic [RFIDX_W-1:0] alu_wbck_idx,
    input  logic [XLEN-1:0]    alu_wbck_dat,
    input  logic               lsu_wbck_valid,
    output logic               lsu_wbck_ready,
    input  logic               lsu_wbck_wen,
    input  logic [RFIDX_W-1:0] lsu_wbck_idx,
    input  logic [XLEN-1:0]    lsu_wbck_dat,
    output logic               wb_dest_wen,
    output logic [RFIDX_W-1:0] wb_dest_idx,
    output logic [XLEN-1:0]    wb_dest_dat,
    output logic               byp_valid,
    output logic               starve_force
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic               wen_q, wen_d;
    logic [RFIDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]    dat_q, dat_d;

    logic force_alu;
    logic alu_fire;
    logic lsu_fire;

    // Readies depend only on the opposite valid and the counter, never on their own valid.
    assign force_alu      = (starve_cnt_q == STARVE_LIM);
    assign lsu_wbck_ready = ~(force_alu & alu_wbck_valid);
    assign alu_wbck_ready = ~lsu_wbck_valid | force_alu;
    assign alu_fire       = alu_wbck_valid & alu_wbck_ready;
    assign lsu_fire       = lsu_wbck_valid & lsu_wbck_ready;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        wen_d        = 1'b0;
        idx_d        = idx_q;
        dat_d        = dat_q;

        if (!alu_wbck_valid || alu_fire) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // x0 writes are consumed but never reach the regfile.
        if (alu_fire) begin
            wen_d = alu_wbck_wen & (alu_wbck_idx != '0);
            idx_d = alu_wbck_idx;
            dat_d = alu_wbck_dat;
        end else if (lsu_fire) begin
            wen_d = lsu_wbck_wen & (lsu_wbck_idx != '0);
            idx_d = lsu_wbck_idx;
            dat_d = lsu_wbck_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            wen_q        <= 1'b0;
            idx_q        <= '0;
            dat_q        <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            wen_q        <= wen_d;
            idx_q        <= idx_d;
            dat_q        <= dat_d;
        end
    end

    assign wb_dest_wen  = wen_q;
    assign wb_dest_idx  = idx_q;
    assign wb_dest_dat  = dat_q;
    assign byp_valid    = wen_q;
    assign starve_force = force_alu;

endmodule

// File: tb/tb_core_ex_wbck.sv
// Bench for core_ex_wbck: directed vector table followed by randomized traffic
// checked against a transaction-level arbitration model.
module tb_core_ex_wbck;

    localparam int XLEN = 32;
    localparam int RFIDX_W = 5;
    localparam int SMAX = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               alu_wbck_valid, alu_wbck_ready, alu_wbck_wen;
    logic [RFIDX_W-1:0] alu_wbck_idx;
    logic [XLEN-1:0]    alu_wbck_dat;
    logic               lsu_wbck_valid, lsu_wbck_ready, lsu_wbck_wen;
    logic [RFIDX_W-1:0] lsu_wbck_idx;
    logic [XLEN-1:0]    lsu_wbck_dat;
    logic               wb_dest_wen;
    logic [RFIDX_W-1:0] wb_dest_idx;
    logic [XLEN-1:0]    wb_dest_dat;
    logic               byp_valid, starve_force;

    core_ex_wbck #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_wbck_valid(alu_wbck_valid), .alu_wbck_ready(alu_wbck_ready),
        .alu_wbck_wen(alu_wbck_wen), .alu_wbck_idx(alu_wbck_idx), .alu_wbck_dat(alu_wbck_dat),
        .lsu_wbck_valid(lsu_wbck_valid), .lsu_wbck_ready(lsu_wbck_ready),
        .lsu_wbck_wen(lsu_wbck_wen), .lsu_wbck_idx(lsu_wbck_idx), .lsu_wbck_dat(lsu_wbck_dat),
        .wb_dest_wen(wb_dest_wen), .wb_dest_idx(wb_dest_idx), .wb_dest_dat(wb_dest_dat),
        .byp_valid(byp_valid), .starve_force(starve_force)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        av, awen;
        logic [4:0]  aidx;
        logic [31:0] adat;
        logic        lv, lwen;
        logic [4:0]  lidx;
        logic [31:0] ldat;
        logic        chk_rdy;
        logic        ear, elr, ef;
        logic        ewen;
        logic [4:0]  eidx;
        logic [31:0] edat;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic r,
                                 input logic av, input logic awen, input logic [4:0] aidx, input logic [31:0] adat,
                                 input logic lv, input logic lwen, input logic [4:0] lidx, input logic [31:0] ldat,
                                 input logic cr, input logic ear, input logic elr, input logic ef,
                                 input logic ewen, input logic [4:0] eidx, input logic [31:0] edat);
        vec_t v;
        v.rst_n = r; v.av = av; v.awen = awen; v.aidx = aidx; v.adat = adat;
        v.lv = lv; v.lwen = lwen; v.lidx = lidx; v.ldat = ldat;
        v.chk_rdy = cr; v.ear = ear; v.elr = elr; v.ef = ef;
        v.ewen = ewen; v.eidx = eidx; v.edat = edat;
        return v;
    endfunction

    task automatic drive(input logic r, input logic av, input logic awen, input logic [4:0] aidx,
                         input logic [31:0] adat, input logic lv, input logic lwen,
                         input logic [4:0] lidx, input logic [31:0] ldat);
        rst_n = r;
        alu_wbck_valid = av; alu_wbck_wen = awen; alu_wbck_idx = aidx; alu_wbck_dat = adat;
        lsu_wbck_valid = lv; lsu_wbck_wen = lwen; lsu_wbck_idx = lidx; lsu_wbck_dat = ldat;
    endtask

    task automatic check_cycle(input int cyc, input logic cr, input logic ear, input logic elr,
                               input logic ef, input logic ewen, input logic [4:0] eidx,
                               input logic [31:0] edat);
        @(negedge clk);
        if (cr) begin
            chk("alu_ready", cyc, 32'(alu_wbck_ready), 32'(ear));
            chk("lsu_ready", cyc, 32'(lsu_wbck_ready), 32'(elr));
            chk("starve_force", cyc, 32'(starve_force), 32'(ef));
        end
        @(posedge clk);
        #1;
        chk("wb_wen", cyc, 32'(wb_dest_wen), 32'(ewen));
        chk("byp_valid", cyc, 32'(byp_valid), 32'(ewen));
        chk("wb_idx", cyc, 32'(wb_dest_idx), 32'(eidx));
        chk("wb_dat", cyc, wb_dest_dat, edat);
    endtask

    vec_t tbl[21];

    // Random-phase reference state
    int          m_wait;
    logic        m_wen;
    logic [4:0]  m_idx;
    logic [31:0] m_dat;

    initial begin
        // Reset with both valid, then STARVE_MAX=3 contention (period 4), x0, wen=0, ALU alone,
        // mid-stream reset, and a forced ALU grant carrying wen=0.
        tbl[0]  = mkv(0, 1,1,5'd1,32'hA1,       1,1,5'd2,32'hB2,    0, 0,0,0, 0,5'd0,32'h0);
        tbl[1]  = mkv(0, 1,1,5'd1,32'hA1,       1,1,5'd2,32'hB2,    1, 0,1,0, 0,5'd0,32'h0);
        tbl[2]  = mkv(1, 1,1,5'd1,32'hA1,       1,1,5'd2,32'hB2,    1, 0,1,0, 1,5'd2,32'hB2);
        tbl[3]  = mkv(1, 1,1,5'd1,32'hA1,       1,1,5'd3,32'hB3,    1, 0,1,0, 1,5'd3,32'hB3);
        tbl[4]  = mkv(1, 1,1,5'd1,32'hA1,       1,1,5'd4,32'hB4,    1, 0,1,0, 1,5'd4,32'hB4);
        tbl[5]  = mkv(1, 1,1,5'd1,32'hA1,       1,1,5'd5,32'hB5,    1, 1,0,1, 1,5'd1,32'hA1);
        tbl[6]  = mkv(1, 1,1,5'd6,32'hA6,       1,1,5'd5,32'hB5,    1, 0,1,0, 1,5'd5,32'hB5);
        tbl[7]  = mkv(1, 0,0,5'd0,32'h0,        1,1,5'd0,32'h1234,  1, 0,1,0, 0,5'd0,32'h1234);
        tbl[8]  = mkv(1, 1,0,5'd7,32'h77,       0,0,5'd0,32'h0,     1, 1,1,0, 0,5'd7,32'h77);
        tbl[9]  = mkv(1, 1,1,5'd5,32'hDEADBEEF, 0,0,5'd0,32'h0,     1, 1,1,0, 1,5'd5,32'hDEADBEEF);
        tbl[10] = mkv(1, 0,0,5'd0,32'h0,        0,0,5'd0,32'h0,     1, 1,1,0, 0,5'd5,32'hDEADBEEF);
        tbl[11] = mkv(1, 0,0,5'd0,32'h0,        1,1,5'd9,32'h99,    1, 0,1,0, 1,5'd9,32'h99);
        tbl[12] = mkv(0, 0,0,5'd0,32'h0,        1,1,5'd10,32'hAA,   1, 0,1,0, 0,5'd0,32'h0);
        tbl[13] = mkv(1, 1,0,5'd7,32'h70,       1,1,5'd11,32'hC1,   1, 0,1,0, 1,5'd11,32'hC1);
        tbl[14] = mkv(1, 1,0,5'd7,32'h70,       1,1,5'd12,32'hC2,   1, 0,1,0, 1,5'd12,32'hC2);
        tbl[15] = mkv(0, 1,0,5'd7,32'h70,       1,1,5'd13,32'hC3,   1, 0,1,0, 0,5'd0,32'h0);
        tbl[16] = mkv(1, 1,0,5'd7,32'h70,       1,1,5'd13,32'hC3,   1, 0,1,0, 1,5'd13,32'hC3);
        tbl[17] = mkv(1, 1,0,5'd7,32'h70,       1,1,5'd14,32'hC4,   1, 0,1,0, 1,5'd14,32'hC4);
        tbl[18] = mkv(1, 1,0,5'd7,32'h70,       1,1,5'd15,32'hC5,   1, 0,1,0, 1,5'd15,32'hC5);
        tbl[19] = mkv(1, 1,0,5'd7,32'h70,       1,1,5'd16,32'hC6,   1, 1,0,1, 0,5'd7,32'h70);
        tbl[20] = mkv(1, 0,0,5'd0,32'h0,        1,1,5'd16,32'hC6,   1, 0,1,0, 1,5'd16,32'hC6);

        drive(0, 0,0,5'd0,32'h0, 0,0,5'd0,32'h0);
        #1;
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].rst_n, tbl[i].av, tbl[i].awen, tbl[i].aidx, tbl[i].adat,
                  tbl[i].lv, tbl[i].lwen, tbl[i].lidx, tbl[i].ldat);
            check_cycle(i, tbl[i].chk_rdy, tbl[i].ear, tbl[i].elr, tbl[i].ef,
                        tbl[i].ewen, tbl[i].eidx, tbl[i].edat);
        end

        begin
            logic        a_v, a_wen, l_v, l_wen, r, frc, g_a, g_l, e_ar, e_lr;
            logic [4:0]  a_idx, l_idx;
            logic [31:0] a_dat, l_dat;
            logic        a_done, l_done;
            a_v = 0; l_v = 0; a_wen = 0; l_wen = 0; a_idx = 0; l_idx = 0; a_dat = 0; l_dat = 0;
            a_done = 1; l_done = 1;
            m_wait = 0; m_wen = 0; m_idx = 0; m_dat = 0;
            for (int c = 0; c < 600; c++) begin
                // Producers hold a pending result until it is granted.
                if (!a_v || a_done) begin
                    a_v   = ($urandom_range(0, 9) < 6);
                    a_wen = ($urandom_range(0, 7) != 0);
                    a_idx = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    a_dat = $urandom;
                end
                if (!l_v || l_done) begin
                    l_v   = ($urandom_range(0, 9) < 5);
                    l_wen = ($urandom_range(0, 7) != 0);
                    l_idx = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    l_dat = $urandom;
                end
                r = (c == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);

                // LSU wins unless the ALU has already waited STARVE_MAX cycles.
                frc  = (m_wait == SMAX);
                g_a  = a_v && (!l_v || frc);
                g_l  = l_v && !g_a;
                e_ar = !l_v || frc;
                e_lr = !(a_v && frc);

                if (!r) begin
                    m_wait = 0; m_wen = 0; m_idx = 0; m_dat = 0;
                end else begin
                    if (g_a) begin
                        m_wen = a_wen && (a_idx != 0); m_idx = a_idx; m_dat = a_dat;
                    end else if (g_l) begin
                        m_wen = l_wen && (l_idx != 0); m_idx = l_idx; m_dat = l_dat;
                    end else begin
                        m_wen = 0;
                    end
                    if (a_v && !g_a) m_wait = (m_wait < SMAX) ? m_wait + 1 : SMAX;
                    else m_wait = 0;
                end

                drive(r, a_v, a_wen, a_idx, a_dat, l_v, l_wen, l_idx, l_dat);
                check_cycle(100 + c, 1'b1, e_ar, e_lr, frc, m_wen, m_idx, m_dat);
                a_done = g_a && r;
                l_done = g_l && r;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ex_wbck.md
Name: core_ex_wbck

Overview:
- Write-back arbitration stage directly upstream of the integer register file write port.
- Accepts completed results from two producers over valid/ready channels: the single-cycle ALU path and the long-pipe LSU path (loads, multi-cycle ops).
- Selects one result per cycle with LSU priority plus ALU anti-starvation, registers it, and drives the regfile write port and a one-cycle bypass to the EX operand mux.

Parameters:
- XLEN, 32, data width (matches CORE_XLEN).
- RFIDX_W, 5, register index width (matches CORE_RFIDX_WIDTH).
- STARVE_MAX, 3, consecutive ALU-blocked cycles after which ALU wins one arbitration; legal range 1..15.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, synchronous, active-low.
- alu_wbck_valid  in  1  ALU result valid.
- alu_wbck_ready  out  1  ALU result accepted this cycle when valid is also high.
- alu_wbck_wen  in  1  instruction writes rd.
- alu_wbck_idx  in  RFIDX_W  ALU destination index.
- alu_wbck_dat  in  XLEN  ALU result.
- lsu_wbck_valid  in  1  long-pipe result valid.
- lsu_wbck_ready  out  1  long-pipe result accepted.
- lsu_wbck_wen  in  1  long-pipe writes rd.
- lsu_wbck_idx  in  RFIDX_W  long-pipe destination index.
- lsu_wbck_dat  in  XLEN  long-pipe result.
- wb_dest_wen  out  1  regfile write enable.
- wb_dest_idx  out  RFIDX_W  regfile write index.
- wb_dest_dat  out  XLEN  regfile write data.
- byp_valid  out  1  bypass valid; equals wb_dest_wen.
- starve_force  out  1  debug: ALU forced-grant cycle.

Behaviour:
- Reset (rst_n low at a clk edge): wb_dest_wen=0, wb_dest_idx=0, wb_dest_dat=0, starve counter=0. Any in-flight result is discarded. Readies are combinational and follow the rules below once the counter is 0.
- force_alu = (starve_cnt == STARVE_MAX); starve_force = force_alu.
- lsu_wbck_ready = ~(force_alu & alu_wbck_valid).
- alu_wbck_ready = ~lsu_wbck_valid | force_alu.
- Readies never depend on their own valid. The regfile never back-pressures, so with one valid channel that channel is always ready.
- Handshake: a channel fires when valid & ready. At most one channel fires per cycle, guaranteed by the ready equations.
- Output register updates at the clk edge after a fire; latency is 1 cycle from handshake to regfile write, and the regfile write occurs on the following edge.
  - wb_dest_wen <= fire & sel_wen & (sel_idx != 0). Writes to x0 are suppressed here.
  - wb_dest_idx and wb_dest_dat load sel_idx and sel_dat on any fire, including wen=0 or idx=0.
  - With no fire, wb_dest_wen <= 0; idx and dat hold.
- Starve counter, width 4:
  - Increments when alu_wbck_valid & ~alu_wbck_ready.
  - Clears to 0 on ALU fire or when alu_wbck_valid is low.
  - Saturates at STARVE_MAX.
- Simultaneous valid, not forced: LSU wins, ALU held, counter increments.
- Simultaneous valid, forced: ALU wins, LSU held; the counter clears on the same edge.
- Producers must hold valid and payload stable until fire. The block does not check this.
- Same-index back-to-back writes are written in grant order; the later one persists.
- byp_valid lets the EX stage forward wb_dest_dat when wb_dest_idx matches an operand index.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with both valids high -> wb_dest_wen=0, idx=0, dat=0 throughout; one cycle after release, LSU fires.
- ALU alone: alu valid, wen=1, idx=5, dat=0xDEADBEEF -> alu_ready=1. Next cycle wb_dest_wen=1, idx=5, dat=0xDEADBEEF, byp_valid=1. The cycle after, wen=0 if ALU valid is low.
- Contention, STARVE_MAX=3: both valid continuously, distinct payloads.
  - LSU fires in cycles 0, 1 and 2.
  - Cycle 3: starve_force=1 and ALU fires.
  - Cycle 4: LSU fires again; the pattern repeats with period 4.
- x0 suppression: LSU wen=1, idx=0, dat=0x1234 -> lsu_ready=1, wb_dest_wen stays 0, wb_dest_dat=0x1234.
- wen=0 consume: ALU valid, wen=0, idx=7 -> ALU fires, wb_dest_wen=0, starve counter clears.
- Mid-stream reset: assert rst_n=0 in the cycle after an LSU fire -> wb_dest_wen=0 at that edge, the pending write is lost, and the counter is 0.
